// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin select arbiter.
// Imported by rr_pick and rr_select_arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_REQ-1:0] req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // One-hot image of a select code, identical to what the downstream decoder produces.
    function automatic req_t decode_sel(input sel_t sel);
        req_t onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request searching ptr, ptr+1, ... modulo 4.
// Outputs the winning index and a found flag; usable stand-alone.
module rr_pick
    import arb_pkg::*;
(
    input  req_t req,
    input  sel_t ptr,
    output sel_t winner,
    output logic found
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner = ptr;
        found  = 1'b0;
        // Walk from the lowest priority offset up so the highest-priority hit is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[sel_t'(ptr + sel_t'(i))]) begin
                winner = sel_t'(ptr + sel_t'(i));
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin owner of the shared 2-to-4 select decoder, with a one-cycle break-before-make gap.
// Optional macro ARB_TIMEOUT_EN forces release after HOLD_MAX consecutive grant cycles.
module rr_select_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [3:0]   Req,
    output logic [3:0]   Grant,
    output logic [1:0]   Select,
    output logic         Grant_valid,
    output logic         Preempt
);

    if ((1 << CNT_W) <= HOLD_MAX) begin : g_cnt_w_too_small
        $error("rr_select_arbiter: CNT_W too narrow for HOLD_MAX");
    end

    state_t state_q, state_d;
    req_t   grant_q, grant_d;
    sel_t   select_q, select_d;
    sel_t   ptr_q, ptr_d;
    logic   valid_q, valid_d;
    logic   preempt_q, preempt_d;

    sel_t   winner;
    logic   found;
    logic   owner_req;
    logic   timeout;

    rr_pick u_pick (
        .req    (Req),
        .ptr    (ptr_q),
        .winner (winner),
        .found  (found)
    );

    assign owner_req = Req[select_q];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds (cycles granted - 1), so HOLD_MAX-1 marks the last allowed cycle.
    assign timeout = (cnt_q == CNT_W'(HOLD_MAX - 1)) && owner_req;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        select_d  = select_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE, GAP: begin
                if (found) begin
                    state_d  = GRANT;
                    grant_d  = decode_sel(winner);
                    select_d = winner;
                    valid_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    valid_d  = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req || timeout) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = sel_t'(select_q + sel_t'(1));
                    preempt_d = timeout;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            select_q  <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign Grant       = grant_q;
    assign Select      = select_q;
    assign Grant_valid = valid_q;
    assign Preempt     = preempt_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Self-checking bench for rr_select_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_rr_select_arbiter;

    localparam int HOLD_MAX = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [3:0] Req;
    logic [3:0] Grant;
    logic [1:0] Select;
    logic       Grant_valid;
    logic       Preempt;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the resource (-1 = nobody), last owner, priority pointer, cycles held.
    int m_owner;
    int m_last;
    int m_ptr;
    int m_hold;
    bit m_pre;

    rr_select_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Req         (Req),
        .Grant       (Grant),
        .Select      (Select),
        .Grant_valid (Grant_valid),
        .Preempt     (Preempt)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    // One clock edge of the arbitration rules, applied to the request vector seen at that edge.
    task automatic model_step(input logic [3:0] r);
        if (m_owner >= 0) begin
            if (!r[m_owner] || (TO_EN && m_hold >= HOLD_MAX)) begin
                m_pre   = r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_hold++;
                m_pre = 1'b0;
            end
        end else begin
            m_pre = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = (m_ptr + i) % 4;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_hold  = 1;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 2'(m_last), (m_owner >= 0), m_pre};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {Grant, Select, Grant_valid, Preempt};
    endfunction

    task automatic cycle(input logic [3:0] r);
        Req = r;
        @(posedge Clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        Req     = 4'b0000;
        Reset_n = 1'b0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Req     = 4'b0000;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 8'h00) begin
            failures++;
            $display("FAIL reset_values: got %b expected %b", dut_vec(), 8'h00);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(4'b0000);
            checks++;
            if (dut_vec() !== 8'h00) begin
                failures++;
                $display("FAIL idle_no_req[%0d]: got %b expected %b", i, dut_vec(), 8'h00);
            end
        end
    endtask

    // Single requester, gap, then pointer-after-release (3) picks index 3 out of 1011.
    task automatic test_single();
        logic [3:0] reqs [6] = '{4'b0100, 4'b0000, 4'b1011, 4'b1011, 4'b0011, 4'b0011};
        logic [7:0] exps [6] = '{8'b0100_10_1_0, 8'b0000_10_0_0, 8'b1000_11_1_0,
                                 8'b1000_11_1_0, 8'b0000_11_0_0, 8'b0001_00_1_0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(reqs[i]);
            checks++;
            if (dut_vec() !== exps[i]) begin
                failures++;
                $display("FAIL single[%0d]: got %b expected %b", i, dut_vec(), exps[i]);
            end
        end
    endtask

    // Pointer at 2 with Req=1011 picks 3, then wraps to 0.
    task automatic test_wrap();
        logic [3:0] reqs [5] = '{4'b0010, 4'b0000, 4'b1011, 4'b0011, 4'b0011};
        logic [7:0] exps [5] = '{8'b0010_01_1_0, 8'b0000_01_0_0, 8'b1000_11_1_0,
                                 8'b0000_11_0_0, 8'b0001_00_1_0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(reqs[i]);
            checks++;
            if (dut_vec() !== exps[i]) begin
                failures++;
                $display("FAIL wrap[%0d]: got %b expected %b", i, dut_vec(), exps[i]);
            end
        end
    endtask

    // A request rising mid-grant must not disturb the owner; it wins only after the gap.
    task automatic test_late_req();
        logic [3:0] reqs [6] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001};
        logic [7:0] exps [6] = '{8'b0010_01_1_0, 8'b0010_01_1_0, 8'b0010_01_1_0,
                                 8'b0010_01_1_0, 8'b0000_01_0_0, 8'b0001_00_1_0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(reqs[i]);
            checks++;
            if (dut_vec() !== exps[i]) begin
                failures++;
                $display("FAIL late_req[%0d]: got %b expected %b", i, dut_vec(), exps[i]);
            end
        end
    endtask

    // All four request; each owner drops after 3 cycles. Order 0,1,2,3,0, single-cycle gaps.
    task automatic test_rotation();
        int         order [$];
        int         expected_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] prev_grant;
        int         zero_run;
        logic [3:0] r;
        do_reset();
        prev_grant = '0;
        zero_run   = 0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_hold == 3) r[m_owner] = 1'b0;
            cycle(r);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rotation_cycle[%0d]: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (Grant == 4'b0000) begin
                zero_run++;
            end else if (prev_grant == 4'b0000) begin
                for (int b = 0; b < 4; b++) if (Grant[b]) order.push_back(b);
                if (order.size() > 1) begin
                    checks++;
                    if (zero_run != 1) begin
                        failures++;
                        $display("FAIL rotation_gap: got %0d dead cycles expected 1", zero_run);
                    end
                end
                zero_run = 0;
            end
            prev_grant = Grant;
        end
        checks++;
        if (order.size() != 5) begin
            failures++;
            $display("FAIL rotation_count: got %0d grants expected 5", order.size());
        end
        for (int k = 0; k < order.size() && k < 5; k++) begin
            checks++;
            if (order[k] != expected_order[k]) begin
                failures++;
                $display("FAIL rotation_order[%0d]: got %0d expected %0d", k, order[k], expected_order[k]);
            end
        end
    endtask

    // Reset between edges clears outputs at once and restarts priority at index 0.
    task automatic test_async_reset();
        do_reset();
        cycle(4'b0010);
        cycle(4'b0000);
        cycle(4'b0010);
        checks++;
        if (dut_vec() !== 8'b0010_01_1_0) begin
            failures++;
            $display("FAIL async_pre: got %b expected %b", dut_vec(), 8'b0010_01_1_0);
        end
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 8'h00) begin
            failures++;
            $display("FAIL async_clear: got %b expected %b", dut_vec(), 8'h00);
        end
        #2;
        Reset_n = 1'b1;
        cycle(4'b0110);
        checks++;
        if (dut_vec() !== 8'b0010_01_1_0) begin
            failures++;
            $display("FAIL async_restart: got %b expected %b", dut_vec(), 8'b0010_01_1_0);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    // Two requesters held forever: owners alternate every HOLD_MAX cycles with a Preempt pulse.
    task automatic test_timeout();
        int own0 = 0;
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 2 * (HOLD_MAX + 1) + 2; c++) begin
            cycle(4'b0011);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_cycle[%0d]: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (Grant == 4'b0001) own0++;
            if (Preempt) pulses++;
        end
        checks++;
        if (own0 != HOLD_MAX + 2 || pulses != 2) begin
            failures++;
            $display("FAIL timeout_counts: got own0=%0d pulses=%0d expected own0=%0d pulses=2",
                     own0, pulses, HOLD_MAX + 2);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cycle(r);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle[%0d] req=%b: got %b expected %b", c, r, dut_vec(), exp_vec());
            end
            checks++;
            if ((Grant & (Grant - 4'd1)) != 4'd0 ||
                (Grant_valid && Grant !== (4'b0001 << Select)) ||
                (Grant_valid !== (Grant != 4'd0))) begin
                failures++;
                $display("FAIL random_invariant[%0d]: got grant=%b sel=%0d valid=%b expected consistent onehot",
                         c, Grant, Select, Grant_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_late_req();
        test_rotation();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- 4-requester round-robin arbiter that owns the shared 2-to-4 select decoder and its downstream resource.
- Picks one requester, drives the registered 2-bit select code and matching one-hot grant, and holds the grant while the request stays high.
- Inserts a one-cycle break-before-make gap between owners, then rotates priority.
- Sits between the requesting blocks and the decoder/shared output stage.

Parameters:
- HOLD_MAX, 15: maximum consecutive grant cycles before forced release; used only with ARB_TIMEOUT_EN.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Req  input  4  request per requester; level, held high for the whole transaction.
- Grant  output  4  one-hot grant, registered; all-zero when nobody owns the resource.
- Select  output  2  binary index of current/last owner, registered; feeds the decoder.
- Grant_valid  output  1  high when Grant is non-zero.
- Preempt  output  1  one-cycle pulse on a timeout release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clocking and reset: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset values: state=IDLE, Grant=4'b0000, Select=2'b00, Grant_valid=0, Preempt=0, Ptr=2'd0, hold counter=0.
- Ptr is the highest-priority index. Search order is Ptr, Ptr+1, Ptr+2, Ptr+3, all modulo 4.
- State IDLE:
  - If Req==0, stay in IDLE with outputs zero.
  - Otherwise, on the next edge go to GRANT with winner w.
  - In that same edge: Grant=1<<w, Select=w, Grant_valid=1, counter=0.
  - Latency from Req sampled high to Grant high is 1 clock.
- State GRANT:
  - While Req[Select]=1 (and no timeout), hold Grant/Select and increment the counter (saturating).
  - At the edge where Req[Select] is sampled 0, go to GAP.
  - In that edge: Grant=0, Grant_valid=0, Ptr=Select+1 (2-bit wrap, 3 becomes 0).
- State GAP:
  - Exactly one dead cycle with Grant=0.
  - At the next edge, arbitrate exactly as IDLE: go to GRANT if any Req is high, else go to IDLE.
  - The minimum dead time between two owners is therefore 1 cycle.
- Select keeps the last owner index in GAP/IDLE; it never changes while Grant is non-zero.
- Grant is always one-hot or zero. Grant equals the decoded Select whenever Grant_valid=1.
- A new Req arriving during GRANT is ignored until the next arbitration edge; no preemption except timeout.
- Simultaneous requests: the Ptr order decides. Example: Ptr=2 and Req=4'b1011 selects index 3.
- Owner drop and other requests in the same cycle: the drop wins, then GAP, then the round-robin pick.
- Reset asserted mid-grant: outputs clear immediately (asynchronous). Priority restarts at index 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - In GRANT, when the counter reaches HOLD_MAX-1 with Req[Select] still high, the next edge goes to GAP as a normal release would.
  - Preempt pulses high for that one cycle (the GAP cycle).
  - Ptr=Select+1.
  - The timed-out requester rejoins arbitration as a normal requester.
  - The owner can therefore hold for at most HOLD_MAX cycles.
- When undefined:
  - No counter logic is built and HOLD_MAX is unused.
  - The grant is held until Req drops.
  - Preempt is tied 0.

Decomposition:
- Package arb_pkg:
  - NUM_REQ=4, SEL_W=2.
  - Enum state_t {IDLE, GRANT, GAP}.
  - Typedef sel_t (logic [SEL_W-1:0]).
- Sub-module rr_pick: purely combinational.
  - Inputs: Req[3:0], Ptr.
  - Outputs: winner index, found flag.
  - Unit-testable on its own.

Test Plan:
- Reset then Req=4'b0100 at cycle 0 -> cycle 1: Grant=4'b0100, Select=2, Grant_valid=1; Req drop -> one GAP cycle, Ptr=3.
- Ptr=0, Req=4'b1111 held, each owner drops after 3 cycles -> grant order 0,1,2,3,0, each separated by exactly 1 zero-Grant cycle.
- Ptr=2, Req=4'b1011 -> Grant=4'b1000, Select=3; after release Ptr wraps to 0 and the next grant goes to index 0.
- Owner 1 holds Req, Req[0] rises mid-grant -> Grant stays 4'b0010, no glitch on Select; index 0 is granted only after GAP.
- ARB_TIMEOUT_EN, HOLD_MAX=15, Req=4'b0011 held -> owner 0 for 15 cycles, Preempt pulse, GAP, owner 1 for 15 cycles, repeat.
- Reset_n low mid-GRANT (asynchronous, between edges) -> Grant=0, Select=0, Grant_valid=0 immediately; after release with Req=4'b0110, index 1 is granted.
